// File: rtl/led7seg_scan_driver.sv
// led7seg_scan_driver: two-digit multiplexed 7-segment driver with per-frame capture, blank phases and leading-zero blanking
module led7seg_scan_driver #(
  parameter int SCAN_DIV = 4,
  parameter bit COMMON_ANODE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dv,
  input  logic [3:0] ch,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame
);
  localparam int PW = $clog2(2 * SCAN_DIV);
  localparam logic [PW-1:0] LAST = PW'(2 * SCAN_DIV - 1);
  localparam logic [PW-1:0] HALF = PW'(SCAN_DIV);
  logic [PW-1:0] p;
  logic [3:0] dv_s, ch_s, digit;
  logic lz_s, tens, lit;
  logic [6:0] pat;
  logic [1:0] en;
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: decode = 7'h3F;
      4'd1: decode = 7'h06;
      4'd2: decode = 7'h5B;
      4'd3: decode = 7'h4F;
      4'd4: decode = 7'h66;
      4'd5: decode = 7'h6D;
      4'd6: decode = 7'h7D;
      4'd7: decode = 7'h07;
      4'd8: decode = 7'h7F;
      4'd9: decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction
  // p is the position the outputs will show after the next edge
  always_comb begin
    tens = p >= HALF;
    digit = tens ? ch_s : dv_s;
    lit = p != '0 && p != HALF && !(tens && lz_s && ch_s == 4'd0);
    pat = lit ? decode(digit) : 7'h00;
    en = lit ? (tens ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      p <= '0;
      dv_s <= 4'd0;
      ch_s <= 4'd0;
      lz_s <= 1'b0;
      frame <= 1'b0;
      seg <= {7{COMMON_ANODE}};
      an <= {2{COMMON_ANODE}};
    end else begin
      p <= p == LAST ? '0 : p + 1'b1;
      if (p == '0) begin
        dv_s <= dv;
        ch_s <= ch;
        lz_s <= blank_lz;
      end
      frame <= p == '0;
      seg <= {7{COMMON_ANODE}} ^ pat;
      an <= {2{COMMON_ANODE}} ^ en;
    end
endmodule

// File: tb/tb_led7seg_scan_driver.sv
// tb_led7seg_scan_driver: directed stimulus with an edge-count model checked every cycle on two configurations
module tb_led7seg_scan_driver;
  logic clk = 0, reset = 0, blank_lz;
  logic [3:0] dv, ch;
  logic [6:0] seg0, seg1;
  logic [1:0] an0, an1;
  logic frame0, frame1;
  int tests = 0, fails = 0, e = 0, n = 0;
  logic [3:0] cd0, cc0, cd1, cc1;
  logic cl0, cl1;
  logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  led7seg_scan_driver dut0 (.clk(clk), .reset(reset), .dv(dv), .ch(ch), .blank_lz(blank_lz),
                            .seg(seg0), .an(an0), .frame(frame0));
  led7seg_scan_driver #(.SCAN_DIV(2), .COMMON_ANODE(0)) dut1 (.clk(clk), .reset(reset), .dv(dv),
                            .ch(ch), .blank_lz(blank_lz), .seg(seg1), .an(an1), .frame(frame1));
  always #5 clk = ~clk;
  function automatic logic [9:0] model(int k, int s, bit ca, logic [3:0] d, logic [3:0] c, logic lz);
    int pos, slot;
    logic [6:0] pat;
    logic [1:0] en;
    logic fr;
    pat = 7'h00;
    en = 2'b00;
    fr = 1'b0;
    if (k > 0) begin
      pos = (k - 1) % (2 * s);
      slot = pos / s;
      fr = pos == 0;
      if (pos % s != 0 && !(slot == 1 && lz && c == 4'd0)) begin
        pat = tab[slot == 1 ? c : d];
        en = slot == 1 ? 2'b10 : 2'b01;
      end
    end
    return {fr, en ^ {2{ca}}, pat ^ {7{ca}}};
  endfunction
  task automatic chk(string nm, logic [9:0] a, logic [9:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, a, x, e);
    end
  endtask
  // n counts edges since reset release; captures happen on the edge that starts each frame
  always @(posedge clk or posedge reset)
    if (reset) begin
      n <= 0;
      {cd0, cc0, cl0} <= '0;
      {cd1, cc1, cl1} <= '0;
    end else begin
      if (n % 8 == 0) begin
        cd0 <= dv;
        cc0 <= ch;
        cl0 <= blank_lz;
      end
      if (n % 4 == 0) begin
        cd1 <= dv;
        cc1 <= ch;
        cl1 <= blank_lz;
      end
      n <= n + 1;
    end
  always @(negedge clk) begin
    chk("model0", {frame0, an0, seg0}, model(n, 4, 1'b1, cd0, cc0, cl0));
    chk("model1", {frame1, an1, seg1}, model(n, 2, 1'b0, cd1, cc1, cl1));
  end
  task automatic tick();
    @(negedge clk);
    e++;
  endtask
  task automatic go(int k);
    while (e < k) tick();
  endtask
  task automatic restart();
    #2 reset = 1;
    #1;
    chk("rst_an0", 10'(an0), 10'h3);
    chk("rst_seg0", 10'(seg0), 10'h7F);
    chk("rst_frame0", 10'(frame0), 10'h0);
    chk("rst_an1", 10'(an1), 10'h0);
    chk("rst_seg1", 10'(seg1), 10'h0);
    @(negedge clk);
    #1 reset = 0;
    e = 0;
  endtask
  initial begin
    dv = 4'd7;
    ch = 4'd3;
    blank_lz = 1'b0;
    restart();
    go(1);
    chk("e1_an", 10'(an0), 10'h3);
    chk("e1_frame", 10'(frame0), 10'h1);
    for (int k = 2; k <= 4; k++) begin
      go(k);
      chk("units_an", 10'(an0), 10'h2);
      chk("units_seg", 10'(seg0), 10'h78);
      if (k == 3) ch = 4'd5;
    end
    go(5);
    chk("blank_an", 10'(an0), 10'h3);
    chk("blank_seg", 10'(seg0), 10'h7F);
    for (int k = 6; k <= 8; k++) begin
      go(k);
      chk("tens_an", 10'(an0), 10'h1);
      chk("tens_seg_old", 10'(seg0), 10'h30);
    end
    go(9);
    chk("e9_frame", 10'(frame0), 10'h1);
    for (int k = 14; k <= 16; k++) begin
      go(k);
      chk("tens_seg_new", 10'(seg0), 10'h12);
    end
    go(19);
    dv = 4'd9;
    ch = 4'd0;
    blank_lz = 1'b1;
    restart();
    go(1);
    chk("rel_frame", 10'(frame0), 10'h1);
    go(2);
    chk("u9_an", 10'(an0), 10'h2);
    chk("u9_seg", 10'(seg0), 10'h10);
    for (int k = 6; k <= 7; k++) begin
      go(k);
      chk("lz_an", 10'(an0), 10'h3);
      chk("lz_seg", 10'(seg0), 10'h7F);
    end
    go(8);
    blank_lz = 1'b0;
    go(14);
    chk("zero_an", 10'(an0), 10'h1);
    chk("zero_seg", 10'(seg0), 10'h40);
    go(16);
    dv = 4'hC;
    go(18);
    chk("dash_seg", 10'(seg0), 10'h3F);
    go(24);
    for (int d = 0; d < 10; d++) begin
      dv = 4'(d);
      go(e + 8);
    end
    dv = 4'd8;
    ch = 4'd3;
    restart();
    go(1);
    chk("ah_e1_frame", 10'(frame1), 10'h1);
    chk("ah_e1_an", 10'(an1), 10'h0);
    go(2);
    chk("ah_e2_an", 10'(an1), 10'h1);
    chk("ah_e2_seg", 10'(seg1), 10'h7F);
    go(3);
    chk("ah_e3_an", 10'(an1), 10'h0);
    chk("ah_e3_seg", 10'(seg1), 10'h0);
    chk("ah_e3_frame", 10'(frame1), 10'h0);
    go(4);
    chk("ah_e4_an", 10'(an1), 10'h2);
    chk("ah_e4_seg", 10'(seg1), 10'h4F);
    go(5);
    chk("ah_e5_frame", 10'(frame1), 10'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
